// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
// Shares one asynchronous-read ROM between two burst requesters.
// Each requester presents a descriptor (start address, word count minus 1).
// One burst is granted at a time with round-robin priority. The ROM words
// are streamed over a single valid/ready channel that carries the owner ID
// and a last-word flag.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req0_valid/ready/addr/len       requester 0 descriptor handshake
//   req1_valid/ready/addr/len       requester 1 descriptor handshake
//   rom_addr, rom_q                 ROM address out, combinational data in
//   out_valid/ready/data/id/last    output word stream
module rom_burst_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [AWIDTH-1:0] req0_len,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [AWIDTH-1:0] req1_len,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_id,
  output logic              out_last
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]        state_r;
  logic [AWIDTH-1:0] cur_addr_r;
  logic [AWIDTH-1:0] remaining_r;
  logic              cur_id_r;
  logic              last_grant_r;

  logic              idle_s;
  logic              stream_s;
  logic              grant_s;
  logic              hs_s;
  logic              last_word_s;

  // State decode; outputs are suppressed during reset so an abandoned
  // burst never shows another word or a last flag.
  always_comb begin
    idle_s      = 1'b0;
    stream_s    = 1'b0;
    if (rst) begin
      idle_s   = 1'b0;
      stream_s = 1'b0;
    end else begin
      idle_s   = (state_r == ST_IDLE);
      stream_s = (state_r == ST_STREAM);
    end
    last_word_s = (remaining_r == {AWIDTH{1'b0}});
  end

  // Round-robin selection: a lone valid requester wins, otherwise the
  // requester that was not granted last time. With nobody valid, ready is
  // parked on the requester that would win the next tie.
  always_comb begin
    grant_s = ~last_grant_r;
    if (req0_valid && !req1_valid) begin
      grant_s = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = ~last_grant_r;
    end
  end

  // Descriptor handshake with the selected requester.
  always_comb begin
    hs_s = 1'b0;
    if (idle_s) begin
      hs_s = grant_s ? req1_valid : req0_valid;
    end else begin
      hs_s = 1'b0;
    end
  end

  assign req0_ready = idle_s && (grant_s == 1'b0);
  assign req1_ready = idle_s && (grant_s == 1'b1);

  assign rom_addr  = cur_addr_r;
  assign out_valid = stream_s;
  assign out_data  = rom_q;
  assign out_id    = cur_id_r;
  assign out_last  = stream_s && last_word_s;

  // Burst FSM and descriptor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= {AWIDTH{1'b0}};
      remaining_r  <= {AWIDTH{1'b0}};
      cur_id_r     <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            cur_addr_r   <= grant_s ? req1_addr : req0_addr;
            remaining_r  <= grant_s ? req1_len  : req0_len;
            cur_id_r     <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (last_word_s) begin
              state_r <= ST_IDLE;
            end else begin
              // Address wraps naturally modulo 2^AWIDTH.
              cur_addr_r  <= cur_addr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
              remaining_r <= remaining_r - {{(AWIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed testbench for rom_burst_arbiter. The ROM is modelled as
// mem[i] = i, so rom_q simply mirrors rom_addr. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
module tb_rom_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_addr, req0_len;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_addr, req1_len;
  logic [7:0] rom_addr;
  logic [7:0] rom_q;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_id, out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] obs, exp_v;

  rom_burst_arbiter #(.DWIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_len(req1_len),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_last(out_last)
  );

  // ROM contents mem[i] = i
  assign rom_q = rom_addr;

  always #5 clk = ~clk;

  assign obs = {out_valid, out_id, out_last, out_data, rom_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = 8'h00; req0_len = 8'h00;
    req1_valid = 1'b0; req1_addr = 8'h00; req1_len = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 19'h0);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, req0_ready, req1_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 010", {out_valid, req0_ready, req1_ready});
    end
    tick();
  endtask

  task automatic test_single_burst();
    req0_valid = 1'b1; req0_addr = 8'h10; req0_len = 8'h03;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a;
      a = 8'h10 + 8'(k);
      exp_v = {1'b1, 1'b0, (k == 3), a, a};
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_word%0d: got %h expected %h", k, obs, exp_v);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: out_valid got %b expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 8'h00; req0_len = 8'h00;
    req1_valid = 1'b1; req1_addr = 8'h80; req1_len = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, req0_ready, req1_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_in_reset: got %b expected 000", {out_valid, req0_ready, req1_ready});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic       id;
      logic [7:0] a;
      id = (i % 2 == 1);
      a  = id ? 8'h80 : 8'h00;
      @(negedge clk);
      n_checks++;
      if ({out_valid, req0_ready, req1_ready} !== {1'b0, ~id, id}) begin
        n_fail++;
        $display("FAIL rr_idle%0d: got %b expected %b", i,
                 {out_valid, req0_ready, req1_ready}, {1'b0, ~id, id});
      end
      tick();
      exp_v = {1'b1, id, 1'b1, a, a};
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rr_word%0d: got %h expected %h", i, obs, exp_v);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    req1_valid = 1'b1; req1_addr = 8'hFE; req1_len = 8'h02;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wrap_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a;
      a = 8'hFE + 8'(k);
      exp_v = {1'b1, 1'b1, (k == 2), a, a};
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL wrap_word%0d: got %h expected %h", k, obs, exp_v);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic       rdy  [5];
    logic [7:0] ed   [5];
    logic       el   [5];
    logic [7:0] got  [3];
    int         n;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ed  = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h22};
    el  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    got = '{8'h00, 8'h00, 8'h00};
    n = 0;
    req0_valid = 1'b1; req0_addr = 8'h20; req0_len = 8'h02;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      out_ready = rdy[j];
      exp_v = {1'b1, 1'b0, el[j], ed[j], ed[j]};
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got %h expected %h", j, obs, exp_v);
      end
      if (out_valid && out_ready) begin
        if (n < 3) got[n] = out_data;
        n++;
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({n[7:0], got[0], got[1], got[2], out_valid} !== {8'd3, 8'h20, 8'h21, 8'h22, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_delivered: count %0d words %h %h %h valid %b expected 3 words 20 21 22 valid 0",
               n, got[0], got[1], got[2], out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    req0_valid = 1'b1; req0_addr = 8'h40; req0_len = 8'h07;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rmb_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a;
      a = 8'h40 + 8'(k);
      exp_v = {1'b1, 1'b0, 1'b0, a, a};
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rmb_word%0d: got %h expected %h", k, obs, exp_v);
      end
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_last, req0_ready, req1_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmb_in_reset: got %b expected 0000",
               {out_valid, out_last, req0_ready, req1_ready});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, rom_addr, req0_ready, req1_ready} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rmb_after_reset: got %h expected %h",
               {out_valid, rom_addr, req0_ready, req1_ready}, {1'b0, 8'h00, 1'b1, 1'b0});
    end
    tick();
    req1_valid = 1'b1; req1_addr = 8'h90; req1_len = 8'h01;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rmb_req1_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] a;
      a = 8'h90 + 8'(k);
      exp_v = {1'b1, 1'b1, (k == 1), a, a};
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rmb_req1_word%0d: got %h expected %h", k, obs, exp_v);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_descriptor_change();
    req0_valid = 1'b1; req0_addr = 8'h30; req0_len = 8'h01;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL desc_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; req0_addr = 8'h70; req0_len = 8'h05;
    exp_v = {1'b1, 1'b0, 1'b0, 8'h30, 8'h30};
    @(negedge clk);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL desc_word0: got %h expected %h", obs, exp_v);
    end
    tick();
    req0_addr = 8'hA5; req0_len = 8'h00;
    exp_v = {1'b1, 1'b0, 1'b1, 8'h31, 8'h31};
    @(negedge clk);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL desc_word1: got %h expected %h", obs, exp_v);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL desc_done: out_valid got %b expected 0", out_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_mid_burst();
    test_descriptor_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Shares one asynchronous-read ROM (ASYNC_ROM-style: `q` valid combinationally from `addr`) between two requesters. Each requester issues a burst descriptor (start address, length). The arbiter grants one burst at a time with round-robin priority and streams the ROM words out over a single valid/ready channel tagged with requester ID and a last flag. It sits between the ROM and consumers such as table-lookup engines and boot/microcode loaders.

## Interface
- `DWIDTH`, 8, ROM data width
- `AWIDTH`, 8, ROM address width; also the width of the burst length field
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 descriptor valid
- `req0_ready`  out  1  requester 0 descriptor accepted when `req0_valid && req0_ready`
- `req0_addr`  in  AWIDTH  requester 0 start address
- `req0_len`  in  AWIDTH  requester 0 word count minus 1 (0 = 1 word)
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_len`  as above, for requester 1
- `rom_addr`  out  AWIDTH  address to ROM
- `rom_q`  in  DWIDTH  ROM read data (combinational from `rom_addr`)
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  DWIDTH  ROM word (equals `rom_q`)
- `out_id`  out  1  requester that owns the current burst
- `out_last`  out  1  final word of the burst

## Operation
- Two states: IDLE and STREAM. Registers: `cur_addr`, `remaining` (AWIDTH each), `cur_id`, `last_grant`.
- IDLE: the `req*_ready` output goes to exactly one requester, combinationally:
  - only one requester valid → it is selected;
  - both valid → the requester != `last_grant` is selected;
  - neither valid → ready goes to the requester != `last_grant`.
- On handshake: `cur_addr` <= req addr, `remaining` <= req len, `cur_id` and `last_grant` <= granted ID, state <= STREAM.
- STREAM:
  - both `req*_ready` = 0;
  - `out_valid` = 1; `out_data` = `rom_q`; `out_id` = `cur_id`; `out_last` = (`remaining` == 0).
- On `out_valid && out_ready` in STREAM:
  - if `remaining` == 0 → IDLE;
  - else `cur_addr` <= `cur_addr` + 1 (modulo 2^AWIDTH, wraps 0xFF→0x00 at AWIDTH=8) and `remaining` <= `remaining` − 1.
- With `out_ready` low, every stream output and `rom_addr` hold stable.
- `rom_addr` = `cur_addr` at all times.
- Descriptor inputs are sampled only at the handshake. Later changes do not affect an active burst.
- A burst is never preempted. The other requester waits until it completes.

## Timing
- Reset values (while `rst` high and after):
  - state IDLE;
  - `cur_addr` 0, `remaining` 0, `cur_id` 0, `last_grant` 1, so requester 0 wins the first tie;
  - `out_valid` 0, `out_last` 0 (not in STREAM);
  - `req0_ready` and `req1_ready` forced to 0 while `rst` = 1.
- Descriptor accepted at edge N → first word valid in the cycle after edge N (1-cycle latency).
- Throughput: one word per cycle while `out_ready` = 1. A burst of len L occupies L+1 STREAM cycles.
- After the last word is accepted, the FSM spends exactly one IDLE cycle before the next grant. Back-to-back bursts therefore have a 1-cycle gap.
- `rst` asserted mid-burst:
  - the burst is abandoned; no further words and no `out_last`;
  - `out_valid` = 0 from the cycle `rst` is high;
  - all registers take their reset values at that edge.
- Simultaneous requests in IDLE: the grant alternates every burst while both stay valid.

## Test plan
- Single burst:
  - stimulus: ROM preloaded mem[i]=i; req0 addr 0x10, len 3; `out_ready` = 1.
  - required: words 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles starting 1 cycle after accept; `out_id` = 0; `out_last` only on 0x13.
- Round-robin tie:
  - stimulus: both requesters held valid from reset; req0 addr 0x00 len 0, req1 addr 0x80 len 0.
  - required: grant order 0, 1, 0, 1; each word separated by one IDLE cycle.
- Wrap-around:
  - stimulus: req1 addr 0xFE, len 2.
  - required: `rom_addr` 0xFE, 0xFF, 0x00; data 0xFE, 0xFF, 0x00; `out_last` on 0x00.
- Backpressure:
  - stimulus: req0 addr 0x20 len 2; `out_ready` toggled 1,0,0,1,1.
  - required: `out_data`, `rom_addr` and `out_last` hold while stalled; exactly 3 words delivered in order, no duplicates.
- Reset mid-burst:
  - stimulus: req0 len 7; assert `rst` for one cycle after 3 words.
  - required: `out_valid` 0 in the reset cycle; afterwards state IDLE; a fresh req1 is granted and its stream starts at its own address.
- Descriptor change during burst:
  - stimulus: change `req0_addr` and `req0_len` while req0's burst is active.
  - required: the burst completes with the originally sampled values.
